// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel/address types and the draw command format.
package fb_pkg;

    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_PIXELS = FB_W * FB_H;
    localparam int ADDR_W    = 15;
    localparam int PIX_W     = 12;

    typedef logic [PIX_W-1:0]  colour_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic {IDLE, CLEAR} arb_state_t;

    typedef struct packed {
        fb_addr_t addr;
        colour_t  colour;
    } draw_cmd_t;

    localparam int       CMD_W     = $bits(draw_cmd_t);
    localparam fb_addr_t LAST_ADDR = fb_addr_t'(FB_PIXELS - 1);

endpackage

// File: rtl/fb_draw_fifo.sv
// Synchronous draw-command FIFO; rd_data shows the head with zero latency.
// Writes while full and reads while empty are ignored; full drives upstream backpressure.
module fb_draw_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [CMD_W-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [CMD_W-1:0] mem [DEPTH];

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rd_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
            end
            if (rd_en && !empty) begin
                rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[PW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM port arbiter: scanout reads > canvas clear > queued draws; reads return 2 cycles after request.
// Draws backpressure through draw_ready (FIFO full); FB_BOUNDS_CHECK_EN drops and counts out-of-range draws.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int DRAW_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_rd_req,
    input  logic [ADDR_W-1:0] disp_rd_addr,
    output logic              disp_rd_valid,
    output logic [PIX_W-1:0]  disp_rd_data,
    input  logic              draw_valid,
    output logic              draw_ready,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [PIX_W-1:0]  draw_colour,
    input  logic              clear_start,
    input  logic [PIX_W-1:0]  clear_colour,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [PIX_W-1:0]  ram_wdata,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic [7:0]        drop_count
);

    arb_state_t       state;
    fb_addr_t         clr_ptr;
    colour_t          clear_colour_q;
    logic             rd_pipe;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             head_ok;
    logic [CMD_W-1:0] head_bits;
    draw_cmd_t        head;
    draw_cmd_t        push_cmd;

    assign push_cmd   = '{addr: draw_addr, colour: draw_colour};
    assign head       = draw_cmd_t'(head_bits);
    assign draw_ready = !fifo_full;
    // Draws drain only when neither a scanout read nor a clear owns the port.
    assign fifo_pop   = !fifo_empty && (state == IDLE) && !disp_rd_req;
    // RAM read data is already aligned with disp_rd_valid.
    assign disp_rd_data = ram_rdata;

    fb_draw_fifo #(
        .DEPTH(DRAW_DEPTH)
    ) u_draw_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (draw_valid),
        .wr_data(push_cmd),
        .rd_en  (fifo_pop),
        .rd_data(head_bits),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

`ifdef FB_BOUNDS_CHECK_EN
    logic [7:0] drop_q;

    assign head_ok    = (head.addr < fb_addr_t'(FB_PIXELS));
    assign drop_count = drop_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (fifo_pop && !head_ok && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end
`else
    assign head_ok    = 1'b1;
    assign drop_count = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            clr_ptr        <= '0;
            clear_colour_q <= '0;
            clear_busy     <= 1'b0;
            clear_done     <= 1'b0;
            rd_pipe        <= 1'b0;
            disp_rd_valid  <= 1'b0;
            ram_addr       <= '0;
            ram_we         <= 1'b0;
            ram_wdata      <= '0;
        end else begin
            rd_pipe       <= disp_rd_req;
            disp_rd_valid <= rd_pipe;
            clear_done    <= 1'b0;
            ram_we        <= 1'b0;

            if (disp_rd_req) begin
                ram_addr <= disp_rd_addr;
            end else if (state == CLEAR) begin
                ram_we    <= 1'b1;
                ram_addr  <= clr_ptr;
                ram_wdata <= clear_colour_q;
            end else if (fifo_pop && head_ok) begin
                ram_we    <= 1'b1;
                ram_addr  <= head.addr;
                ram_wdata <= head.colour;
            end

            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state          <= CLEAR;
                        clear_colour_q <= clear_colour;
                        clr_ptr        <= '0;
                        clear_busy     <= 1'b1;
                    end
                end
                CLEAR: begin
                    // The pointer moves only on cycles the clear actually wrote.
                    if (!disp_rd_req) begin
                        if (clr_ptr == LAST_ADDR) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            clr_ptr <= clr_ptr + fb_addr_t'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
